// File: rtl/atmega_io_master.sv
// Command-driven initiator for the ATmega-style peripheral register bus.
// Turns write/read/RMW/poll commands into single-cycle rd/wr strobes and returns one response per command.
module atmega_io_master #(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned TIMEOUT_WIDTH     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [2:0]                   cmd_op_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]        cmd_data_i,
    input  logic [DATA_WIDTH-1:0]        cmd_mask_i,
    input  logic [TIMEOUT_WIDTH-1:0]     cmd_timeout_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_WIDTH-1:0]        rsp_data_o,
    output logic                         rsp_err_o,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
    output logic                         wr_o,
    output logic                         rd_o,
    output logic [DATA_WIDTH-1:0]        bus_o,
    input  logic [DATA_WIDTH-1:0]        bus_i
);

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_POLL   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [2:0]                     r_op;
    logic [BUS_ADDR_DATA_LEN-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]          r_data;
    logic [DATA_WIDTH-1:0]          r_mask;
    logic [TIMEOUT_WIDTH-1:0]       r_cnt;

    logic                           w_accept;
    logic                           w_rsp_done;
    logic                           w_is_rmw;
    logic                           w_poll_match;
    logic [DATA_WIDTH-1:0]          w_rmw_data;

    logic                           w_ready_nxt;
    logic                           w_valid_nxt;
    logic [DATA_WIDTH-1:0]          w_rsp_data_nxt;
    logic                           w_rsp_err_nxt;
    logic [BUS_ADDR_DATA_LEN-1:0]   w_addr_nxt;
    logic                           w_wr_nxt;
    logic                           w_rd_nxt;
    logic [DATA_WIDTH-1:0]          w_bus_nxt;

    assign w_accept     = cmd_valid_i & cmd_ready_o;
    assign w_rsp_done   = rsp_valid_o & rsp_ready_i;
    assign w_is_rmw     = (r_op == OP_SET) || (r_op == OP_CLEAR) || (r_op == OP_TOGGLE);
    assign w_poll_match = ((bus_i ^ r_data) & r_mask) == '0;

    // Read-modify-write result, formed from the live read data on the RD->WR edge
    always_comb begin
        w_rmw_data = bus_i;
        case (r_op)
            OP_SET:    w_rmw_data = bus_i | r_data;
            OP_CLEAR:  w_rmw_data = bus_i & ~r_data;
            OP_TOGGLE: w_rmw_data = bus_i ^ r_data;
            default:   w_rmw_data = bus_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op_i)
                        OP_WRITE:                                    w_state_nxt = S_WR;
                        OP_READ, OP_SET, OP_CLEAR, OP_TOGGLE, OP_POLL: w_state_nxt = S_RD;
                        default:                                     w_state_nxt = S_RESP;
                    endcase
                end
            end
            S_RD: begin
                if (r_op == OP_POLL) begin
                    if (w_poll_match || (r_cnt == '0)) begin
                        w_state_nxt = S_RESP;
                    end
                end else if (w_is_rmw) begin
                    w_state_nxt = S_WR;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WR:    w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    // Strobes follow the next state; rsp_valid lags entry into RESP by one cycle.
    always_comb begin
        w_ready_nxt    = (w_state_nxt == S_IDLE);
        w_rd_nxt       = (w_state_nxt == S_RD);
        w_wr_nxt       = (w_state_nxt == S_WR);
        w_valid_nxt    = (r_state == S_RESP) && (w_state_nxt == S_RESP);
        w_addr_nxt     = '0;
        w_bus_nxt      = '0;
        w_rsp_data_nxt = rsp_data_o;
        w_rsp_err_nxt  = rsp_err_o;

        if (w_rd_nxt || w_wr_nxt) begin
            w_addr_nxt = w_accept ? cmd_addr_i : r_addr;
        end
        if (w_wr_nxt) begin
            w_bus_nxt = w_accept ? cmd_data_i : w_rmw_data;
        end

        if ((r_state != S_RESP) && (w_state_nxt == S_RESP)) begin
            case (r_state)
                S_IDLE: begin
                    w_rsp_data_nxt = '0;
                    w_rsp_err_nxt  = 1'b1;
                end
                S_RD: begin
                    w_rsp_data_nxt = bus_i;
                    w_rsp_err_nxt  = (r_op == OP_POLL) && !w_poll_match;
                end
                S_WR: begin
                    w_rsp_data_nxt = bus_o;
                    w_rsp_err_nxt  = 1'b0;
                end
                default: begin
                    w_rsp_data_nxt = rsp_data_o;
                    w_rsp_err_nxt  = rsp_err_o;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            addr_o      <= '0;
            wr_o        <= 1'b0;
            rd_o        <= 1'b0;
            bus_o       <= '0;
        end else begin
            cmd_ready_o <= w_ready_nxt;
            rsp_valid_o <= w_valid_nxt;
            rsp_data_o  <= w_rsp_data_nxt;
            rsp_err_o   <= w_rsp_err_nxt;
            addr_o      <= w_addr_nxt;
            wr_o        <= w_wr_nxt;
            rd_o        <= w_rd_nxt;
            bus_o       <= w_bus_nxt;
        end
    end

    // Command capture and poll retry counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op   <= cmd_op_i;
            r_addr <= cmd_addr_i;
            r_data <= cmd_data_i;
            r_mask <= cmd_mask_i;
            r_cnt  <= cmd_timeout_i;
        end else if ((r_state == S_RD) && (r_op == OP_POLL) && (w_state_nxt == S_RD)) begin
            r_cnt  <= r_cnt - TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_atmega_io_master.sv
// Self-checking bench for atmega_io_master: scoreboarded commands against a small peripheral model.
module tb_atmega_io_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [7:0]  cmd_addr_i;
    logic [7:0]  cmd_data_i;
    logic [7:0]  cmd_mask_i;
    logic [15:0] cmd_timeout_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic [7:0]  addr_o;
    logic        wr_o;
    logic        rd_o;
    logic [7:0]  bus_o;
    logic [7:0]  bus_i;

    atmega_io_master #(
        .BUS_ADDR_DATA_LEN(8),
        .DATA_WIDTH(8),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i),
        .cmd_timeout_i(cmd_timeout_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .addr_o(addr_o), .wr_o(wr_o), .rd_o(rd_o), .bus_o(bus_o), .bus_i(bus_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus monitor: cycle count, strobe counts and last strobe details
    int         cyc = 0;
    int         rd_count = 0;
    int         wr_count = 0;
    int         both_hi = 0;
    int         idle_nz = 0;
    int         last_rd_cyc = -1;
    int         last_wr_cyc = -1;
    logic [7:0] last_rd_addr = 8'h00;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rd_o === 1'b1) begin
            rd_count     <= rd_count + 1;
            last_rd_addr <= addr_o;
            last_rd_cyc  <= cyc;
        end
        if (wr_o === 1'b1) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= addr_o;
            last_wr_data <= bus_o;
            last_wr_cyc  <= cyc;
        end
        if (rd_o === 1'b1 && wr_o === 1'b1) both_hi <= both_hi + 1;
        if (rd_o === 1'b0 && wr_o === 1'b0 && (addr_o !== 8'h00 || bus_o !== 8'h00)) idle_nz <= idle_nz + 1;
    end

    // Peripheral model: a fixed register value, or a per-read sequence for polling
    logic [7:0] reg_val = 8'h00;
    logic       use_seq = 1'b0;
    int         rd_base = 0;
    logic [7:0] rd_seq [8];
    int         rd_idx;

    always_comb begin
        rd_idx = rd_count - rd_base;
        if (rd_idx > 7) rd_idx = 7;
        if (rd_idx < 0) rd_idx = 0;
        bus_i = 8'h00;
        if (rd_o === 1'b1) bus_i = use_seq ? rd_seq[rd_idx[2:0]] : reg_val;
    end

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         reads;
        int         writes;
    } exp_t;

    typedef struct {
        bit         got;
        logic [7:0] data;
        logic       err;
        int         lat;
        int         reads;
        int         writes;
        bit         stable;
        bit         post_ok;
        int         t_acc;
        int         r_cyc;
    } obs_t;

    exp_t exp_q[$];

    function automatic logic [33:0] pack_obs(input obs_t o);
        return {o.got, o.data, o.err, 8'(o.lat), 8'(o.reads), 8'(o.writes)};
    endfunction

    function automatic logic [33:0] pack_exp(input exp_t e);
        return {1'b1, e.data, e.err, 8'(e.lat), 8'(e.reads), 8'(e.writes)};
    endfunction

    // Wait for ready, present one command for exactly one accepting edge
    task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] mask, input logic [15:0] tmo, output int t_acc);
        int n = 0;
        while (cmd_ready_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        t_acc = -1000;
        if (cmd_ready_o === 1'b1) begin
            cmd_valid_i   = 1'b1;
            cmd_op_i      = op;
            cmd_addr_i    = addr;
            cmd_data_i    = data;
            cmd_mask_i    = mask;
            cmd_timeout_i = tmo;
            @(posedge clk_i); #1;
            t_acc         = cyc;
            cmd_valid_i   = 1'b0;
            cmd_op_i      = 3'($urandom);
            cmd_addr_i    = 8'($urandom);
            cmd_data_i    = 8'($urandom);
            cmd_mask_i    = 8'($urandom);
            cmd_timeout_i = 16'($urandom);
        end
    endtask

    // Run one command to completion, holding off the response for 'hold' cycles
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] mask, input logic [15:0] tmo, input int hold,
                          output obs_t o);
        int n = 0;
        int rd0 = rd_count;
        int wr0 = wr_count;
        o.got = 0; o.data = 8'hxx; o.err = 1'bx; o.lat = -1;
        o.stable = 1; o.post_ok = 0; o.r_cyc = -1;
        issue(op, addr, data, mask, tmo, o.t_acc);
        while (rsp_valid_o !== 1'b1 && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (rsp_valid_o === 1'b1) begin
            o.got  = 1;
            o.lat  = cyc - o.t_acc;
            o.data = rsp_data_o;
            o.err  = rsp_err_o;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i); #1;
                if (rsp_valid_o !== 1'b1 || rsp_data_o !== o.data || rsp_err_o !== o.err || cmd_ready_o !== 1'b0)
                    o.stable = 0;
            end
            rsp_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rsp_ready_i = 1'b0;
            o.r_cyc   = cyc;
            o.post_ok = (rsp_valid_o === 1'b0) && (cmd_ready_o === 1'b1);
        end
        o.reads  = rd_count - rd0;
        o.writes = wr_count - wr0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b1;
        #2 rst_n_i = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, addr_o, wr_o, rd_o, bus_o} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h exp 0", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, addr_o, wr_o, rd_o, bus_o});
        end
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        n_tests++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: got %b exp 0", cmd_ready_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: got ready=%b valid=%b exp ready=1 valid=0", cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_write();
        obs_t o;
        exp_t e;
        exp_q.push_back('{8'hA5, 1'b0, 2, 0, 1});
        do_cmd(3'd0, 8'h03, 8'hA5, 8'h00, 16'd0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL write_rsp: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        n_tests++;
        if ({last_wr_addr, last_wr_data, 8'(last_wr_cyc - o.t_acc)} !== {8'h03, 8'hA5, 8'h00}) begin
            n_fail++;
            $display("FAIL write_strobe: got addr=%h data=%h off=%0d exp addr=03 data=a5 off=0",
                     last_wr_addr, last_wr_data, last_wr_cyc - o.t_acc);
        end
    endtask

    task automatic test_read();
        obs_t o;
        exp_t e;
        reg_val = 8'h3C;
        exp_q.push_back('{8'h3C, 1'b0, 2, 1, 0});
        do_cmd(3'd1, 8'h04, 8'h00, 8'h00, 16'd0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL read_rsp: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        n_tests++;
        if ({last_rd_addr, 8'(last_rd_cyc - o.t_acc)} !== {8'h04, 8'h00}) begin
            n_fail++;
            $display("FAIL read_strobe: got addr=%h off=%0d exp addr=04 off=0", last_rd_addr, last_rd_cyc - o.t_acc);
        end
    endtask

    task automatic test_rmw();
        logic [2:0] ops [3] = '{3'd2, 3'd3, 3'd4};
        logic [7:0] wv  [3] = '{8'h5F, 8'h50, 8'h5F};
        obs_t o;
        exp_t e;
        reg_val = 8'h50;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{wv[k], 1'b0, 3, 1, 1});
            do_cmd(ops[k], 8'h00, 8'h0F, 8'h00, 16'd0, 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if (pack_obs(o) !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL rmw_rsp op=%0d: got %h exp %h", ops[k], pack_obs(o), pack_exp(e));
            end
            n_tests++;
            if ({last_wr_addr, last_wr_data, 8'(last_rd_cyc - o.t_acc), 8'(last_wr_cyc - last_rd_cyc)} !==
                {8'h00, wv[k], 8'h00, 8'h01}) begin
                n_fail++;
                $display("FAIL rmw_strobe op=%0d: got addr=%h data=%h rdoff=%0d gap=%0d exp addr=00 data=%h rdoff=0 gap=1",
                         ops[k], last_wr_addr, last_wr_data, last_rd_cyc - o.t_acc, last_wr_cyc - last_rd_cyc, wv[k]);
            end
        end
    endtask

    task automatic test_poll();
        obs_t o;
        exp_t e;
        use_seq = 1'b1;
        // matches on the third read
        rd_seq = '{8'h00, 8'h7F, 8'h85, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rd_base = rd_count;
        exp_q.push_back('{8'h85, 1'b0, 4, 3, 0});
        do_cmd(3'd5, 8'h07, 8'h80, 8'h80, 16'd5, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL poll_match: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        // never matches, timeout 2 -> three reads
        rd_seq = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        rd_base = rd_count;
        exp_q.push_back('{8'h7F, 1'b1, 4, 3, 0});
        do_cmd(3'd5, 8'h07, 8'h80, 8'h80, 16'd2, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL poll_timeout: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        // timeout 0 -> exactly one read
        rd_base = rd_count;
        exp_q.push_back('{8'h7F, 1'b1, 2, 1, 0});
        do_cmd(3'd5, 8'h07, 8'h80, 8'h80, 16'd0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL poll_zero_timeout: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        // mask ignores low bits: 0x3A & 0xF0 == 0x35 & 0xF0 on the first read
        rd_seq = '{8'h3A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_base = rd_count;
        exp_q.push_back('{8'h3A, 1'b0, 2, 1, 0});
        do_cmd(3'd5, 8'h09, 8'h35, 8'hF0, 16'd3, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL poll_masked: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        use_seq = 1'b0;
    endtask

    task automatic test_illegal();
        logic [2:0] ops [2] = '{3'd7, 3'd6};
        obs_t o;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{8'h00, 1'b1, 1, 0, 0});
            do_cmd(ops[k], 8'h12, 8'h34, 8'h56, 16'd3, 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if (pack_obs(o) !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL illegal_op%0d: got %h exp %h", ops[k], pack_obs(o), pack_exp(e));
            end
        end
    endtask

    task automatic test_hold();
        obs_t o;
        exp_t e;
        exp_q.push_back('{8'h5A, 1'b0, 2, 0, 1});
        do_cmd(3'd0, 8'h10, 8'h5A, 8'h00, 16'd0, 10, o);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL hold_rsp: got %h exp %h", pack_obs(o), pack_exp(e));
        end
        n_tests++;
        if ({o.stable, o.post_ok} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_stable: got stable=%b post=%b exp 1 1", o.stable, o.post_ok);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        exp_t e;
        reg_val = 8'hC3;
        exp_q.push_back('{8'hC3, 1'b0, 2, 1, 0});
        exp_q.push_back('{8'h99, 1'b0, 2, 0, 1});
        do_cmd(3'd1, 8'h20, 8'h00, 8'h00, 16'd0, 0, o1);
        do_cmd(3'd0, 8'h21, 8'h99, 8'h00, 16'd0, 0, o2);
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o1) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL b2b_first: got %h exp %h", pack_obs(o1), pack_exp(e));
        end
        e = exp_q.pop_front();
        n_tests++;
        if (pack_obs(o2) !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL b2b_second: got %h exp %h", pack_obs(o2), pack_exp(e));
        end
        n_tests++;
        if (o2.t_acc - o1.r_cyc !== 1 || o1.post_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: got gap=%0d post=%b exp gap=1 post=1", o2.t_acc - o1.r_cyc, o1.post_ok);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int t;
        int wr0;
        reg_val = 8'h50;
        wr0 = wr_count;
        issue(3'd2, 8'h00, 8'h0F, 8'h00, 16'd0, t);
        n_tests++;
        if (rd_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_in_rd: got rd_o=%b exp 1", rd_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, addr_o, wr_o, rd_o, bus_o} !== 28'h0) begin
            n_fail++;
            $display("FAIL mid_rst_async: got %h exp 0", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, addr_o, wr_o, rd_o, bus_o});
        end
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got %b exp 1", cmd_ready_o);
        end
        repeat (4) @(posedge clk_i);
        #1;
        n_tests++;
        if (wr_count - wr0 !== 0 || rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_no_write: got writes=%0d valid=%b exp writes=0 valid=0", wr_count - wr0, rsp_valid_o);
        end
    endtask

    task automatic test_bus_rules();
        n_tests++;
        if (both_hi !== 0 || idle_nz !== 0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bus_rules: got both_hi=%0d idle_nonzero=%0d pending=%0d exp 0 0 0",
                     both_hi, idle_nz, exp_q.size());
        end
    endtask

    initial begin
        cmd_valid_i   = 1'b0;
        cmd_op_i      = 3'd0;
        cmd_addr_i    = 8'h00;
        cmd_data_i    = 8'h00;
        cmd_mask_i    = 8'h00;
        cmd_timeout_i = 16'd0;
        rsp_ready_i   = 1'b0;
        for (int i = 0; i < 8; i++) rd_seq[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_rmw();
        test_poll();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_mid_rmw();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/atmega_io_master.md
# atmega_io_master

Command-driven initiator for the ATmega-style peripheral register bus (addr/wr/rd/data-in/data-out) used by the PIO and sibling peripherals. It accepts single commands over a valid/ready interface: write, read, bit set/clear/toggle (read-modify-write), and poll-until-match with timeout. It converts each command into correctly timed strobe cycles and returns one response per command. It sits between a host-side controller (debug bridge, sequencer, soft-core assist) and the shared peripheral bus.

## Interface
- BUS_ADDR_DATA_LEN, 8, peripheral bus address width
- DATA_WIDTH, 8, bus data width
- TIMEOUT_WIDTH, 16, width of poll retry counter
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  block can accept a command
- cmd_op_i  in  3  0 WRITE, 1 READ, 2 SET, 3 CLEAR, 4 TOGGLE, 5 POLL, 6-7 illegal
- cmd_addr_i  in  BUS_ADDR_DATA_LEN  target register address
- cmd_data_i  in  DATA_WIDTH  write data / bit mask for SET-CLEAR-TOGGLE / compare value for POLL
- cmd_mask_i  in  DATA_WIDTH  POLL compare mask (ignored otherwise)
- cmd_timeout_i  in  TIMEOUT_WIDTH  POLL extra retries after first read
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes response
- rsp_data_o  out  DATA_WIDTH  result data
- rsp_err_o  out  1  illegal op or POLL timeout
- addr_o  out  BUS_ADDR_DATA_LEN  bus address
- wr_o  out  1  write strobe, one cycle per write
- rd_o  out  1  read strobe, one cycle per read
- bus_o  out  DATA_WIDTH  write data to peripherals
- bus_i  in  DATA_WIDTH  read data from peripherals (combinational response to rd_o/addr_o)

## Operation
- All command fields are captured into internal registers on acceptance (cmd_valid_i & cmd_ready_o at a rising edge); inputs may change afterwards.
- FSM states:
  - IDLE: cmd_ready_o=1.
  - RD: rd_o=1; bus_i sampled into the data register at the end of the cycle.
  - WR: wr_o=1.
  - RESP: rsp_valid_o=1.
- Transitions from IDLE on acceptance:
  - WRITE -> WR -> RESP.
  - READ -> RD -> RESP.
  - SET/CLEAR/TOGGLE -> RD -> WR -> RESP.
  - POLL -> RD (repeats).
  - illegal op -> RESP with rsp_err_o=1 and rsp_data_o=0.
- RMW write data = read OR mask (SET), read AND ~mask (CLEAR), read XOR mask (TOGGLE). The write uses the same address as the read.
- POLL:
  - Each RD cycle compares (bus_i & mask) == (data & mask).
  - On match -> RESP, err=0.
  - On mismatch with retry counter 0 -> RESP, err=1.
  - Otherwise decrement the counter and stay in RD.
  - Total reads ≤ cmd_timeout_i+1.
- rsp_data_o:
  - WRITE: the written data.
  - READ and POLL: the last sampled bus_i.
  - RMW: the value written.
- RESP holds rsp_valid_o and data stable until rsp_ready_i. The handshake returns the FSM to IDLE. No new command is accepted in the handshake cycle.
- Bus outputs are idle-zero: addr_o and bus_o are 0 whenever wr_o and rd_o are both 0, so multiple masters can be OR-combined. wr_o and rd_o are never high together.
- All outputs are registered.

## Timing
- Reset (rst_n_i low, immediate and asynchronous):
  - FSM goes to IDLE.
  - cmd_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0.
  - addr_o=0, wr_o=0, rd_o=0, bus_o=0.
- cmd_ready_o goes 1 on the first rising edge after rst_n_i deasserts.
- Command accepted at edge T:
  - WRITE/READ: strobe during cycle T..T+1; rsp_valid_o high from T+2.
  - RMW: rd_o during T..T+1, wr_o during T+1..T+2; rsp_valid_o from T+3.
  - POLL matching on read k (1-based): rsp_valid_o from T+1+k.
  - Illegal op: rsp_valid_o from T+1.
- Response handshake at edge R: rsp_valid_o=0 and cmd_ready_o=1 from R. Next command accepted at the earliest at edge R+1.
- Reset mid-operation: strobes drop immediately and any pending response is discarded. An RMW interrupted between RD and WR performs no write.
- cmd_timeout_i=0: POLL performs exactly one read.
- Max timeout: 2^TIMEOUT_WIDTH reads, with no counter wrap.

## Test plan
- WRITE addr 0x03 data 0xA5 -> one wr_o pulse with addr_o=0x03, bus_o=0xA5; rsp_data_o=0xA5, err=0; rsp_valid_o two cycles after acceptance.
- READ addr 0x04 with bus_i=0x3C while rd_o -> single rd_o pulse; rsp_data_o=0x3C; addr_o/bus_o return to 0 after the strobe.
- SET/CLEAR/TOGGLE addr 0x00, mask 0x0F, register reads 0x50:
  - SET writes 0x5F.
  - CLEAR writes 0x50.
  - TOGGLE writes 0x5F.
  - Each is rd then wr on consecutive cycles; response equals the written value.
- POLL mask 0x80 value 0x80 timeout 5, bus_i bit7 set on the 3rd read -> exactly 3 rd_o pulses, err=0, rsp_data_o = 3rd sample.
- POLL never matching with timeout 2 -> exactly 3 reads, err=1. Op 7 -> immediate response err=1, no strobes.
- Hold rsp_ready_i low 10 cycles -> response stable, cmd_ready_o=0. Assert rst_n_i low during an RMW RD cycle -> no wr_o, all outputs 0 asynchronously, cmd_ready_o=1 one edge after release.
